fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch and phase sequencer of the 4-bit CPU.
- Addresses program ROM and latches the instruction word.
- Drives the control decoder's inputs: opcode, phase, C, Z.
- Consumes the decoder's 13-bit control word to redirect the PC and to update the flag register.

Parameters:
- PC_W, 12, program counter / ROM address width.
- ROM_W, 8, ROM data width; word = opcode[7:4], operand[3:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rom_data  in  ROM_W  ROM read data; combinational from rom_addr, valid same cycle.
- ctrl  in  13  control word from decoder; field positions from package constants.
- alu_c  in  1  ALU carry-out, sampled on load_flag.
- alu_z  in  1  ALU zero, sampled on load_flag.
- step  in  1  single-step request; used only with SINGLE_STEP_EN.
- rom_addr  out  PC_W  current PC.
- opcode  out  4  latched instruction opcode.
- operand  out  4  latched immediate/operand nibble.
- phase  out  1  1 only in EXEC state.
- flag_c  out  1  registered carry flag.
- flag_z  out  1  registered zero flag.

Behaviour:
- Reset (async, active-high) clears everything to 0: pc, opcode, operand, addr_lo, flag_c, flag_z. State goes to FETCH, so phase=0.
- Reset asserted mid-instruction aborts that instruction; no partial PC or flag update survives.
- FETCH (phase=0):
  - {opcode,operand} <= rom_data; pc <= pc+1.
  - If rom_data[7:4] is a jump-class opcode (JC=0, JNC=1, JZ=8, JNZ=9, JMP=12), go to FETCH_EXT; otherwise go to EXEC.
- FETCH_EXT (phase=0):
  - addr_lo <= rom_data; pc <= pc+1; go to EXEC.
  - Jump target = {operand, addr_lo} (12 bits).
- EXEC (phase=1, exactly one cycle):
  - If ctrl[CTRL_LOADPC]: pc <= {operand, addr_lo}.
  - If ctrl[CTRL_LOADFLAG]: flag_c <= alu_c, flag_z <= alu_z.
  - Always go to FETCH.
  - Other ctrl fields are ignored by this block.
- Latency: non-jump instruction takes 2 cycles, jump-class takes 3. The first FETCH after reset reads address 0.
- Flags are stable throughout FETCH/FETCH_EXT. A flag update in EXEC becomes visible to the next instruction's EXEC.
- A not-taken conditional jump still consumes its address word: pc ends at old pc+2.
- PC arithmetic is modulo 2^PC_W: pc=0xFFF increments to 0x000, no error. A 2-word instruction straddling 0xFFF takes its low byte from 0x000.
- Simultaneous LOADPC and LOADFLAG in one EXEC are both applied.
- opcode/operand hold their values from FETCH until the next FETCH.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - FETCH only proceeds when step=1 that cycle; otherwise pc, IR and state hold.
  - FETCH_EXT and EXEC are never stalled.
  - step is a synchronous level input; holding step=1 runs at full speed.
- Undefined: step is ignored and the block free-runs.

Decomposition:
- Package cpu_pkg holds:
  - state enum (FETCH, FETCH_EXT, EXEC).
  - opcode localparams OP_JC..OP_NORM.
  - control-word bit-index constants CTRL_LOADPC, CTRL_LOADFLAG and the other fields.
  - function is_jump(opcode).
- The decoder shares cpu_pkg.
- Single module; no sub-module needed. The PC (load/increment/wrap) may optionally be split out as pc_counter.

Test Plan:
- Reset, then ROM[0]=0x4A (LIT 10):
  - FETCH with rom_addr=0; next cycle phase=1, opcode=4, operand=0xA.
  - Next FETCH at rom_addr=1.
- ROM[0..1]=0xC3,0x45 (JMP 0x345), ctrl LOADPC=1 in EXEC:
  - 3 cycles later rom_addr=0x345, phase=0.
- JC not taken: ROM 0x03,0x10, ctrl LOADPC=0 → next fetch at 0x002, flags unchanged.
- CMPI in EXEC with LOADFLAG=1, alu_c=1, alu_z=1 → flag_c=flag_z=1 from the following cycle. Flags hold through a later EXEC with LOADFLAG=0.
- PC wrap: force pc to 0xFFF with a non-jump word → next fetch rom_addr=0x000.
- Reset during FETCH_EXT of a JMP → outputs 0 and state FETCH immediately (async). After release, fetch resumes at 0x000.
- SINGLE_STEP_EN: step=0 for 5 cycles → rom_addr and opcode frozen. One-cycle step pulse → exactly one instruction executes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: FSM states, opcodes and control-word layout.
// Used by fetch_sequencer and the control decoder.
package cpu_pkg;

  localparam int PC_W   = 12;
  localparam int ROM_W  = 8;
  localparam int CTRL_W = 13;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    FETCH_EXT = 2'd1,
    EXEC      = 2'd2
  } state_t;

  localparam logic [3:0] OP_JC   = 4'd0;
  localparam logic [3:0] OP_JNC  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_LIT  = 4'd4;
  localparam logic [3:0] OP_LD   = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_CMPI = 4'd7;
  localparam logic [3:0] OP_JZ   = 4'd8;
  localparam logic [3:0] OP_JNZ  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_SUBI = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_AND  = 4'd13;
  localparam logic [3:0] OP_OR   = 4'd14;
  localparam logic [3:0] OP_NORM = 4'd15;

  localparam int CTRL_LOADPC   = 0;
  localparam int CTRL_LOADFLAG = 1;
  localparam int CTRL_LOADA    = 2;
  localparam int CTRL_LOADOUT  = 3;
  localparam int CTRL_MEMWR    = 4;
  localparam int CTRL_ALU_LSB  = 5;
  localparam int CTRL_ALU_W    = 3;
  localparam int CTRL_SRCB_LSB = 8;
  localparam int CTRL_SRCB_W   = 2;
  localparam int CTRL_CIN      = 10;
  localparam int CTRL_SRCA_LSB = 11;
  localparam int CTRL_SRCA_W   = 2;

  // Jump-class instructions carry a second word: the low address byte.
  function automatic logic is_jump(input logic [3:0] op);
    unique case (op)
      OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: is_jump = 1'b1;
      default:                              is_jump = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter: load has priority over increment, wraps modulo 2^W.
module pc_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/phase sequencer of the 4-bit CPU: ROM addressing, IR latch, PC redirect, flags.
// Optional SINGLE_STEP_EN: FETCH advances only while step=1.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = 12,
  parameter int ROM_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROM_W-1:0]  rom_data,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              step,
  output logic [PC_W-1:0]   rom_addr,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic              phase,
  output logic              flag_c,
  output logic              flag_z
);

  state_t           state;
  logic [ROM_W-1:0] addr_lo;
  logic             go;
  logic             pc_inc;
  logic             pc_load;
  logic [PC_W-1:0]  target;
  logic             unused_ctrl;

`ifdef SINGLE_STEP_EN
  assign go = step;
`else
  logic unused_step;
  assign go          = 1'b1;
  assign unused_step = step;
`endif

  assign unused_ctrl = ^ctrl;
  assign target      = PC_W'({operand, addr_lo});

  assign pc_inc  = ((state == FETCH) && go) || (state == FETCH_EXT);
  assign pc_load = (state == EXEC) && ctrl[CTRL_LOADPC];

  pc_counter #(
    .W(PC_W)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (target),
    .pc       (rom_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      phase   <= 1'b0;
      opcode  <= '0;
      operand <= '0;
      addr_lo <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (go) begin
            opcode  <= rom_data[7:4];
            operand <= rom_data[3:0];
            if (is_jump(rom_data[7:4])) begin
              state <= FETCH_EXT;
            end else begin
              state <= EXEC;
              phase <= 1'b1;
            end
          end
        end
        FETCH_EXT: begin
          addr_lo <= rom_data;
          state   <= EXEC;
          phase   <= 1'b1;
        end
        EXEC: begin
          if (ctrl[CTRL_LOADFLAG]) begin
            flag_c <= alu_c;
            flag_z <= alu_z;
          end
          state <= FETCH;
          phase <= 1'b0;
        end
        default: begin
          state <= FETCH;
          phase <= 1'b0;
        end
      endcase
    end
  end

endmodule
